// File: rtl/pu_slave_spi_frame_ctrl.sv
// Frame sequencer for the SPI slave driver: groups single-word transactions into
// fixed-length frames over double-buffered TX/RX memories swapped only between frames.
module pu_slave_spi_frame_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_WORDS = 4,
    parameter int ADDR_WIDTH  = $clog2(FRAME_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs,
    input  logic                  spi_ready,
    input  logic                  spi_prepare,
    input  logic [DATA_WIDTH-1:0] spi_data_out,
    output logic [DATA_WIDTH-1:0] spi_data_in,
    input  logic                  tx_wr,
    input  logic [ADDR_WIDTH-1:0] tx_addr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  swap_req,
    output logic                  swap_pending,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 2);
    localparam logic [CNT_W-1:0] FW    = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] FW_P1 = CNT_W'(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_END  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      nxt_ptr;
    logic                  tx_sel_q, tx_sel_d;
    logic                  rx_sel_q, rx_sel_d;
    logic                  swap_pending_q, swap_pending_d;
    logic [DATA_WIDTH-1:0] spi_data_in_q, spi_data_in_d;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  ready_prev_q, prep_prev_q;
    logic                  ready_rise, prep_rise;
    logic                  rx_we;
    logic [ADDR_WIDTH-1:0] rx_waddr;

    logic [DATA_WIDTH-1:0] tx_mem [0:1][0:FRAME_WORDS-1];
    logic [DATA_WIDTH-1:0] rx_mem [0:1][0:FRAME_WORDS-1];

    assign ready_rise = spi_ready & ~ready_prev_q;
    assign prep_rise  = spi_prepare & ~prep_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            tx_sel_q       <= 1'b0;
            rx_sel_q       <= 1'b0;
            swap_pending_q <= 1'b0;
            spi_data_in_q  <= '0;
            rx_data_q      <= '0;
            ready_prev_q   <= 1'b1;
            prep_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            tx_sel_q       <= tx_sel_d;
            rx_sel_q       <= rx_sel_d;
            swap_pending_q <= swap_pending_d;
            spi_data_in_q  <= spi_data_in_d;
            rx_data_q      <= rx_mem[rx_sel_q][rx_addr];
            ready_prev_q   <= spi_ready;
            prep_prev_q    <= spi_prepare;
        end
    end

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[~tx_sel_q][tx_addr] <= tx_data;
        if (rx_we) rx_mem[~rx_sel_q][rx_waddr] <= spi_data_out;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        tx_sel_d       = tx_sel_q;
        rx_sel_d       = rx_sel_q;
        swap_pending_d = swap_pending_q | swap_req;
        spi_data_in_d  = spi_data_in_q;
        rx_we          = 1'b0;
        rx_waddr       = cnt_q[ADDR_WIDTH-1:0];
        nxt_ptr        = ptr_q + ONE;
        case (state_q)
            S_IDLE: begin
                ptr_d = '0;
                cnt_d = '0;
                // A request arriving in IDLE is applied at once, so word 0 comes from the new bank.
                if (swap_pending_q || swap_req) begin
                    tx_sel_d       = ~tx_sel_q;
                    swap_pending_d = 1'b0;
                end
                spi_data_in_d = tx_mem[tx_sel_d][0];
                if (!spi_cs) state_d = S_XFER;
            end
            S_XFER: begin
                if (prep_rise) begin
                    spi_data_in_d = (nxt_ptr < FW) ? tx_mem[tx_sel_q][nxt_ptr[ADDR_WIDTH-1:0]] : '0;
                end
                if (ready_rise) begin
                    rx_we = (cnt_q < FW);
                    if (cnt_q != FW_P1) cnt_d = cnt_q + ONE;
                    if (ptr_q != FW)    ptr_d = nxt_ptr;
                end
                if (spi_cs) state_d = S_END;
            end
            S_END: begin
                if (cnt_q == FW) rx_sel_d = ~rx_sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_XFER);
        frame_done  = (state_q == S_END) && (cnt_q == FW);
        frame_error = (state_q == S_END) && (cnt_q != FW);
    end

    assign spi_data_in  = spi_data_in_q;
    assign rx_data      = rx_data_q;
    assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_pu_slave_spi_frame_ctrl.sv
// Self-checking bench for pu_slave_spi_frame_ctrl: directed frame table, reset
// abort sequence and randomized frames against an array-based frame model.
module tb_pu_slave_spi_frame_ctrl;

    localparam int DW = 8;
    localparam int FW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_cs, spi_ready, spi_prepare;
    logic [DW-1:0] spi_data_out, spi_data_in;
    logic          tx_wr;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_data;
    logic          swap_req, swap_pending;
    logic [AW-1:0] rx_addr;
    logic [DW-1:0] rx_data;
    logic          frame_done, frame_error, busy;

    pu_slave_spi_frame_ctrl #(.DATA_WIDTH(DW), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_ready(spi_ready),
        .spi_prepare(spi_prepare), .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
        .tx_wr(tx_wr), .tx_addr(tx_addr), .tx_data(tx_data), .swap_req(swap_req),
        .swap_pending(swap_pending), .rx_addr(rx_addr), .rx_data(rx_data),
        .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(posedge clk) begin
        if (frame_done)  done_cnt <= done_cnt + 1;
        if (frame_error) err_cnt  <= err_cnt + 1;
    end

    // Frame-level model: TX/RX banks plus which bank is active/visible.
    logic [DW-1:0] m_tx [2][FW];
    logic [DW-1:0] m_rx [2][FW];
    bit            m_txsel, m_rxsel, m_pend;
    logic [DW-1:0] mosi_v [8];

    typedef struct {
        int          n;
        int          mode;
        bit          cs_rdy;
        bit          wr_new;
        logic [31:0] shadow;
        logic [47:0] mosi;
        int          exp_done;
        int          exp_err;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] dv);
        tx_wr = 1'b1; tx_addr = AW'(a); tx_data = dv;
        m_tx[~m_txsel][a] = dv;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic swap_idle();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        m_txsel ^= 1'b1;
        check("pend_idle", swap_pending, 0);
        check("sdi_idle", spi_data_in, m_tx[m_txsel][0]);
    endtask

    task automatic do_word(input logic [DW-1:0] mosi, input bit last_cs, output logic [DW-1:0] miso);
        miso = spi_data_in;
        spi_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        spi_prepare = 1'b1;
        @(negedge clk);
        spi_prepare = 1'b0; spi_data_out = mosi;
        @(negedge clk);
        spi_ready = 1'b1;
        if (last_cs) spi_cs = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_rx();
        for (int a = 0; a < FW; a++) begin
            rx_addr = AW'(a);
            @(negedge clk);
            check($sformatf("rx[%0d]", a), rx_data, m_rx[m_rxsel][a]);
        end
    endtask

    // mode: 0 none, 1 swap in IDLE before frame, 2 swap mid-frame, 3 swap with cs fall
    task automatic run_frame(input int n, input int mode, input bit cs_rdy, output int d, output int e);
        int d0, e0;
        logic [DW-1:0] miso, expv;
        d0 = done_cnt; e0 = err_cnt;
        if (mode == 1) swap_idle();
        if (mode == 3) swap_req = 1'b1;
        spi_cs = 1'b0;
        @(negedge clk);
        swap_req = 1'b0;
        if (mode == 3) m_txsel ^= 1'b1;
        check("busy_start", busy, 1);
        for (int k = 0; k < n; k++) begin
            if (mode == 2 && k == 1) begin
                swap_req = 1'b1;
                @(negedge clk);
                swap_req = 1'b0;
                m_pend = 1'b1;
                check("pend_mid", swap_pending, 1);
            end
            do_word(mosi_v[k], cs_rdy && (k == n - 1), miso);
            expv = (k < FW) ? m_tx[m_txsel][k] : 8'h00;
            check($sformatf("miso[%0d]", k), miso, expv);
            if (k < FW) m_rx[~m_rxsel][k] = mosi_v[k];
        end
        if (!cs_rdy) begin
            spi_cs = 1'b1;
            @(negedge clk);
        end
        check("busy_end", busy, 0);
        if (m_pend) check("pend_end", swap_pending, 1);
        @(negedge clk); @(negedge clk);
        if (m_pend) begin
            m_txsel ^= 1'b1;
            m_pend = 1'b0;
            check("pend_clr", swap_pending, 0);
        end
        if (n == FW) m_rxsel ^= 1'b1;
        d = done_cnt - d0;
        e = err_cnt - e0;
    endtask

    initial begin
        int d, e, d0, e0, n, mode;
        bit cs_rdy;
        logic [DW-1:0] miso;

        vecs[0] = '{4, 0, 0, 0, 32'h0,         48'h11_22_33_44_00_00, 1, 0};
        vecs[1] = '{2, 0, 0, 0, 32'h0,         48'h99_88_00_00_00_00, 0, 1};
        vecs[2] = '{5, 0, 0, 0, 32'h0,         48'h01_02_03_04_05_00, 0, 1};
        vecs[3] = '{4, 2, 0, 1, 32'h55667788,  48'hA0_A1_A2_A3_00_00, 1, 0};
        vecs[4] = '{4, 0, 0, 0, 32'h0,         48'hB0_B1_B2_B3_00_00, 1, 0};
        vecs[5] = '{4, 3, 0, 1, 32'h9ABCDEF0,  48'hC0_C1_C2_C3_00_00, 1, 0};
        vecs[6] = '{4, 0, 1, 0, 32'h0,         48'hD0_D1_D2_D3_00_00, 1, 0};
        vecs[7] = '{1, 0, 0, 0, 32'h0,         48'hE0_00_00_00_00_00, 0, 1};

        m_txsel = 1'b0; m_rxsel = 1'b0; m_pend = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < FW; a++) begin m_tx[b][a] = '0; m_rx[b][a] = '0; end

        rst = 1'b0;
        spi_cs = 1'b1; spi_ready = 1'b1; spi_prepare = 1'b0; spi_data_out = '0;
        tx_wr = 1'b0; tx_addr = '0; tx_data = '0; swap_req = 1'b0; rx_addr = '0;
        @(negedge clk);
        check("rst_sdi", spi_data_in, 0);
        check("rst_rxd", rx_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_error, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", swap_pending, 0);
        rst = 1'b1;
        @(negedge clk);

        host_write(0, 8'hA1); host_write(1, 8'hB2); host_write(2, 8'hC3); host_write(3, 8'hD4);
        swap_idle();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr_new)
                for (int a = 0; a < FW; a++) host_write(a, vecs[i].shadow[8*(3-a) +: 8]);
            for (int k = 0; k < 6; k++) mosi_v[k] = vecs[i].mosi[8*(5-k) +: 8];
            run_frame(vecs[i].n, vecs[i].mode, vecs[i].cs_rdy, d, e);
            check($sformatf("vec%0d_done", i), d, vecs[i].exp_done);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check_rx();
        end

        // Asynchronous reset in the middle of word 2: frame discarded, no pulse.
        spi_cs = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mosi_v[k] = 8'h70 + 8'(k);
            do_word(mosi_v[k], 1'b0, miso);
            check($sformatf("rmiso[%0d]", k), miso, m_tx[m_txsel][k]);
            m_rx[~m_rxsel][k] = mosi_v[k];
        end
        spi_ready = 1'b0;
        @(negedge clk);
        d0 = done_cnt; e0 = err_cnt;
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sdi", spi_data_in, 0);
        check("arst_rxd", rx_data, 0);
        check("arst_done", frame_done, 0);
        check("arst_err", frame_error, 0);
        check("arst_pend", swap_pending, 0);
        spi_cs = 1'b1; spi_ready = 1'b1; spi_prepare = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_txsel = 1'b0; m_rxsel = 1'b0; m_pend = 1'b0;
        @(negedge clk);
        check("arst_nodone", done_cnt - d0, 0);
        check("arst_noerr", err_cnt - e0, 0);
        for (int k = 0; k < FW; k++) mosi_v[k] = 8'h11 * 8'(k + 1);
        run_frame(FW, 0, 1'b0, d, e);
        check("post_rst_done", d, 1);
        check("post_rst_err", e, 0);
        check_rx();

        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 4);
            for (int w = 0; w < n; w++) host_write($urandom_range(0, FW - 1), DW'($urandom));
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 3);
            if (mode == 2 && n < 2) mode = 0;
            cs_rdy = 1'($urandom_range(0, 1));
            for (int k = 0; k < 6; k++) mosi_v[k] = DW'($urandom);
            run_frame(n, mode, cs_rdy, d, e);
            check($sformatf("rnd%0d_done", r), d, (n == FW) ? 1 : 0);
            check($sformatf("rnd%0d_err", r), e, (n == FW) ? 0 : 1);
            check_rx();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pu_slave_spi_frame_ctrl.md
Name: pu_slave_spi_frame_ctrl

Overview:
- Frame sequencer for the SPI slave driver. It turns the driver's single-word transactions into fixed-length frames of FRAME_WORDS words.
- Transmit words come from a double-buffered TX memory that the processor writes. Received words go into a double-buffered RX memory that the processor reads.
- Buffer swaps happen only between frames, so the processor never sees a half-updated frame.
- Sits between the SPI slave driver (system side) and the processor unit's data bus.

Parameters:
DATA_WIDTH, 8, SPI word width; must equal the driver's DATA_WIDTH
FRAME_WORDS, 4, words per frame; must be ≥2
ADDR_WIDTH, $clog2(FRAME_WORDS), width of the word-address ports

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
spi_cs  input  1  chip select, already synchronous to clk (same signal the driver sees); low = frame active
spi_ready  input  1  driver ready; rising edge = one word completed
spi_prepare  input  1  driver prepare; high while the last bit of the current word is shifting
spi_data_out  input  DATA_WIDTH  word received by the driver in the last transaction
spi_data_in  output  DATA_WIDTH  word the driver will transmit next (registered)
tx_wr  input  1  write strobe into the TX shadow buffer
tx_addr  input  ADDR_WIDTH  TX shadow word address
tx_data  input  DATA_WIDTH  TX shadow write data
swap_req  input  1  one-cycle request to swap the TX buffers at the next frame boundary
swap_pending  output  1  swap requested, not yet applied
rx_addr  input  ADDR_WIDTH  RX visible-buffer read address
rx_data  output  DATA_WIDTH  RX read data, 1-cycle latency
frame_done  output  1  one-cycle pulse: complete frame received, RX buffers swapped
frame_error  output  1  one-cycle pulse: frame aborted (short) or overrun (long); RX discarded
busy  output  1  high while state is XFER

Behaviour:
- Reset (rst=0, async): state=IDLE; ptr=0; word count=0; tx_sel=0; rx_sel=0; swap_pending=0; spi_data_in=0; rx_data=0; frame_done=0; frame_error=0; busy=0. Memory contents are not reset.
- Edge detection: spi_ready and spi_prepare are each registered once. Rising edge = current value high AND previous value low. Previous values reset to 1 (ready) and 0 (prepare), so no spurious edge after reset.
- TX memory: two banks. The active bank is tx_sel; the shadow bank is !tx_sel.
  - tx_wr writes the shadow bank using the tx_sel of the current cycle.
  - A swap toggles tx_sel. After a swap, the shadow bank holds stale data until the host rewrites it.
- RX memory: two banks. The fill bank is !rx_sel; the visible bank is rx_sel.
  - rx_data <= visible[rx_addr] every cycle.
- swap_req sets swap_pending; swap_pending stays set until applied. swap_req while already pending has no extra effect.
- IDLE:
  - If swap_pending: toggle tx_sel, clear swap_pending.
  - spi_data_in <= active[0], using the post-swap bank if a swap occurs in the same cycle.
  - spi_cs==0 → XFER, with ptr=0 and count=0.
- XFER (busy=1):
  - spi_prepare rising: spi_data_in <= active[ptr+1] if ptr+1<FRAME_WORDS, else 0.
  - spi_ready rising:
    - If count<FRAME_WORDS: fill[count] <= spi_data_out.
    - count increments, saturating at FRAME_WORDS+1.
    - ptr <= ptr+1, saturating at FRAME_WORDS.
  - spi_cs==1 → END.
- END (one cycle):
  - count==FRAME_WORDS: rx_sel toggles and frame_done=1.
  - Otherwise: frame_error=1 and rx_sel is unchanged.
  - → IDLE.
- spi_data_in reaches the driver at least 2 clk before its first sclk sample. This holds because the SPI clock is ≥4× slower than clk.
- Simultaneous events:
  - swap_req during XFER: applied in the first IDLE cycle after END.
  - spi_ready rising in the same cycle spi_cs rises: the word is stored first, then END evaluates the updated count.
- Any illegal state encoding → IDLE.
- Reset mid-frame: the frame is discarded; no pulse is emitted.

Test Plan:
- Write TX shadow [A1,B2,C3,D4] then pulse swap_req in IDLE → next cycle swap_pending=0, then spi_data_in=A1. Run a 4-word frame with MOSI [11,22,33,44] → MISO [A1,B2,C3,D4], one frame_done pulse, rx_addr 0..3 reads 11,22,33,44.
- 2-word frame (cs raised early) → frame_error pulse, no frame_done, RX visible bank still holds the previous frame's values.
- 5-word frame → 5th MISO word is 00, 5th MOSI word not stored, frame_error pulse.
- swap_req mid-frame with new shadow [55,66,77,88] → current frame completes with old data, swap_pending high until the IDLE cycle after END; next frame transmits 55…88.
- Assert rst=0 asynchronously between clk edges during word 2 → all outputs 0 immediately. After release, a full frame behaves as in scenario 1 with tx_sel=0.
- Pulse swap_req in the same cycle the driver lowers spi_cs from IDLE → frame transmits from the new bank, starting with its word 0.
